// File: rtl/input_control_pkg.sv
// Shared types and default constants for the time-setting input control block.
package input_control_pkg;

    localparam int DEFAULT_SEL_WIDTH = 2;

    typedef logic [DEFAULT_SEL_WIDTH-1:0] sel_t;

    localparam sel_t DEFAULT_SEL_RESET = '0;

endpackage : input_control_pkg

// File: rtl/ena_rise_detect.sv
// Rise detector for one debounced button, evaluated only on enable strobes.
module ena_rise_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ena,
    input  logic i_in,
    output logic o_rise
);

    logic prev;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    // prev resets high so a button held through reset release must be released before it acts.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            prev <= 1'b1;
        end else if (i_ena) begin
            prev <= i_in;
        end
    end

    assign o_rise = i_ena & i_in & ~prev;

endmodule : ena_rise_detect

// File: rtl/input_control.sv
// Time-setting input control: write-mode toggle and a wrapping field-select counter.
module input_control
    import input_control_pkg::*;
#(
    parameter int                   SEL_WIDTH = DEFAULT_SEL_WIDTH,
    parameter logic [SEL_WIDTH-1:0] SEL_RESET = SEL_WIDTH'(DEFAULT_SEL_RESET)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ena,
    input  logic                 i_wr_pulse,
    input  logic                 i_sel_inc_pulse,
    input  logic                 i_sel_dec_pulse,
    output logic                 o_wr_toggle,
    output logic [SEL_WIDTH-1:0] o_sel_val
);

    logic                 rise_wr;
    logic                 rise_inc;
    logic                 rise_dec;
    logic [SEL_WIDTH-1:0] sel_next;

    ena_rise_detect u_wr_rise (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ena   (i_ena),
        .i_in    (i_wr_pulse),
        .o_rise  (rise_wr)
    );

    ena_rise_detect u_inc_rise (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ena   (i_ena),
        .i_in    (i_sel_inc_pulse),
        .o_rise  (rise_inc)
    );

    ena_rise_detect u_dec_rise (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ena   (i_ena),
        .i_in    (i_sel_dec_pulse),
        .o_rise  (rise_dec)
    );

    // Simultaneous inc and dec cancel; arithmetic wraps modulo 2^SEL_WIDTH.
    always_comb begin
        // NOTE: default assignment first so no path leaves sel_next unassigned (no latch).
        sel_next = o_sel_val;
        if (rise_inc && !rise_dec) begin
            sel_next = o_sel_val + SEL_WIDTH'(1);
        end else if (rise_dec && !rise_inc) begin
            sel_next = o_sel_val - SEL_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_wr_toggle <= 1'b0;
            o_sel_val   <= SEL_RESET;
        end else begin
            if (rise_wr) begin
                o_wr_toggle <= ~o_wr_toggle;
            end
            o_sel_val <= sel_next;
        end
    end

endmodule : input_control

// File: tb/tb_input_control.sv
// Directed self-checking bench for input_control with hand-computed expectations.
module tb_input_control;
    import input_control_pkg::*;

    logic i_clk;
    logic i_reset;
    logic i_ena;
    logic i_wr_pulse;
    logic i_sel_inc_pulse;
    logic i_sel_dec_pulse;
    logic o_wr_toggle;
    sel_t o_sel_val;

    int total = 0;
    int bad   = 0;

    input_control dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_ena           (i_ena),
        .i_wr_pulse      (i_wr_pulse),
        .i_sel_inc_pulse (i_sel_inc_pulse),
        .i_sel_dec_pulse (i_sel_dec_pulse),
        .o_wr_toggle     (o_wr_toggle),
        .o_sel_val       (o_sel_val)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock with the given strobe level; outputs sampled 1 ns after the edge.
    // Outside reset, a cycle without i_ena must leave both outputs untouched.
    task automatic cyc(input logic ena);
        logic wr_before;
        sel_t sel_before;
        logic check_hold;
        wr_before  = o_wr_toggle;
        sel_before = o_sel_val;
        check_hold = !ena && i_reset;
        i_ena = ena;
        @(posedge i_clk);
        #1;
        if (check_hold) begin
            check("hold_wr", 32'(o_wr_toggle), 32'(wr_before));
            check("hold_sel", 32'(o_sel_val), 32'(sel_before));
        end
    endtask

    // One 20 ns strobe period: enabled cycle followed by an idle cycle.
    task automatic strobe();
        cyc(1'b1);
        cyc(1'b0);
    endtask

    task automatic pulse_inc();
        i_sel_inc_pulse = 1'b1;
        strobe();
        i_sel_inc_pulse = 1'b0;
        strobe();
    endtask

    task automatic pulse_dec();
        i_sel_dec_pulse = 1'b1;
        strobe();
        i_sel_dec_pulse = 1'b0;
        strobe();
    endtask

    sel_t inc_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sel_t dec_exp [5] = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0};

    initial begin
        i_reset         = 1'b0;
        i_ena           = 1'b0;
        i_wr_pulse      = 1'b0;
        i_sel_inc_pulse = 1'b0;
        i_sel_dec_pulse = 1'b0;

        // Reset for 5 strobes, then idle 100 ns
        for (int i = 0; i < 5; i++) strobe();
        check("rst_wr", 32'(o_wr_toggle), 32'd0);
        check("rst_sel", 32'(o_sel_val), 32'd0);
        i_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            strobe();
            check("idle_wr", 32'(o_wr_toggle), 32'd0);
            check("idle_sel", 32'(o_sel_val), 32'd0);
        end

        // Write toggle 0->1->0->1, new value visible right after the enabled edge
        for (int i = 0; i < 3; i++) begin
            i_wr_pulse = 1'b1;
            cyc(1'b1);
            check("wr_toggle", 32'(o_wr_toggle), 32'((i % 2) == 0));
            cyc(1'b0);
            i_wr_pulse = 1'b0;
            strobe();
        end

        // Increment wrap 0->1->2->3->0->1
        for (int i = 0; i < 5; i++) begin
            pulse_inc();
            check("inc_wrap", 32'(o_sel_val), 32'(inc_exp[i]));
        end

        // Decrement wrap 1->0->3->2->1->0
        for (int i = 0; i < 5; i++) begin
            pulse_dec();
            check("dec_wrap", 32'(o_sel_val), 32'(dec_exp[i]));
        end

        // Held across 4 strobes: exactly one increment (0 -> 1)
        i_sel_inc_pulse = 1'b1;
        for (int i = 0; i < 4; i++) strobe();
        i_sel_inc_pulse = 1'b0;
        strobe();
        check("hold_once", 32'(o_sel_val), 32'd1);

        // Pulse entirely between strobes is missed
        i_sel_inc_pulse = 1'b1;
        cyc(1'b0);
        i_sel_inc_pulse = 1'b0;
        cyc(1'b0);
        strobe();
        check("gated_miss", 32'(o_sel_val), 32'd1);

        // inc and dec on the same strobe cancel
        i_sel_inc_pulse = 1'b1;
        i_sel_dec_pulse = 1'b1;
        cyc(1'b1);
        check("inc_dec_same", 32'(o_sel_val), 32'd1);
        cyc(1'b0);
        i_sel_inc_pulse = 1'b0;
        i_sel_dec_pulse = 1'b0;
        strobe();

        // Write and increment together: wr 1->0, sel 1->2
        i_wr_pulse      = 1'b1;
        i_sel_inc_pulse = 1'b1;
        cyc(1'b1);
        check("both_wr", 32'(o_wr_toggle), 32'd0);
        check("both_sel", 32'(o_sel_val), 32'd2);
        cyc(1'b0);
        i_wr_pulse      = 1'b0;
        i_sel_inc_pulse = 1'b0;
        strobe();

        // Bring wr back to 1, then reset mid-sequence without i_ena
        i_wr_pulse = 1'b1;
        strobe();
        i_wr_pulse = 1'b0;
        strobe();
        check("pre_rst_wr", 32'(o_wr_toggle), 32'd1);
        check("pre_rst_sel", 32'(o_sel_val), 32'd2);
        i_reset = 1'b0;
        cyc(1'b0);
        check("midrst_wr", 32'(o_wr_toggle), 32'd0);
        check("midrst_sel", 32'(o_sel_val), 32'd0);

        // wr held high through reset release: no toggle until it falls and rises
        i_wr_pulse = 1'b1;
        strobe();
        i_reset = 1'b1;
        for (int i = 0; i < 3; i++) strobe();
        check("held_rst_wr", 32'(o_wr_toggle), 32'd0);
        i_wr_pulse = 1'b0;
        strobe();
        check("held_rst_low", 32'(o_wr_toggle), 32'd0);
        i_wr_pulse = 1'b1;
        cyc(1'b1);
        check("held_rst_rise", 32'(o_wr_toggle), 32'd1);
        i_wr_pulse = 1'b0;
        strobe();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_input_control
